// File: rtl/signal_sequence_driver_bfm_pkg.sv
// -----------------------------------------------------------------------------
// signal_seq_pkg
// Purpose : shared types and constants for the signal sequence driver BFM.
//   seq_state_e : sequencer state (idle / applying an entry)
//   STATS_CNT_W : width of the applied-entry counter (optional statistics)
//   OVF_CNT_W   : width of the rejected-push counter (optional statistics)
// Optional statistics are enabled with the SIGNAL_SEQ_STATS_EN macro.
// -----------------------------------------------------------------------------
package signal_seq_pkg;

  typedef enum logic {
    SEQ_IDLE  = 1'b0,
    SEQ_APPLY = 1'b1
  } seq_state_e;

  localparam int STATS_CNT_W = 32;
  localparam int OVF_CNT_W   = 16;

  // Queue entry width: {hold, mask, value}
  function automatic int entry_width(input int signal_size, input int hold_w);
    return hold_w + 2 * signal_size;
  endfunction

endpackage : signal_seq_pkg

// File: rtl/signal_sequence_driver_bfm_if.sv
// -----------------------------------------------------------------------------
// signal_sequence_driver_bfm_if
// Purpose : push handshake between the proxy transactor and the sequence driver.
//   push_valid   : entry offered (master -> slave)
//   push_ready   : queue not full (slave -> master)
//   push_signals : value to drive
//   push_mask    : 1 = bit takes push_signals, 0 = bit keeps its current value
//   push_hold    : extra hold cycles (entry drives for hold+1 cycles)
// Modports: master (proxy side), slave (driver side).
// -----------------------------------------------------------------------------
interface signal_sequence_driver_bfm_if #(
  parameter int SIGNAL_SIZE = 4,
  parameter int HOLD_W      = 8
);
  logic                   push_valid;
  logic                   push_ready;
  logic [SIGNAL_SIZE-1:0] push_signals;
  logic [SIGNAL_SIZE-1:0] push_mask;
  logic [HOLD_W-1:0]      push_hold;

  modport master (
    output push_valid,
    output push_signals,
    output push_mask,
    output push_hold,
    input  push_ready
  );

  modport slave (
    input  push_valid,
    input  push_signals,
    input  push_mask,
    input  push_hold,
    output push_ready
  );
endinterface : signal_sequence_driver_bfm_if

// File: rtl/signal_sequence_driver_bfm_fifo.sv
// -----------------------------------------------------------------------------
// signal_seq_fifo
// Purpose : synchronous FIFO holding queued driver entries.
// Ports:
//   clock, reset_n : clock (posedge) and async active-low reset
//   wr_en, wr_data : write request / data (ignored while full or flushing)
//   rd_en, rd_data : pop request / head-of-queue data (show-ahead)
//   flush          : synchronous clear of pointers and occupancy
//   full, empty    : occupancy flags
//   level          : number of stored entries
// DEPTH must be a power of two so pointers wrap naturally.
// -----------------------------------------------------------------------------
module signal_seq_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;

  logic w_wr;
  logic w_rd;

  assign full  = (r_count == LVL_W'(DEPTH));
  assign empty = (r_count == '0);
  assign level = r_count;

  // A full queue rejects writes even when a pop happens at the same edge;
  // flush drops both operations.
  assign w_wr = wr_en && !full && !flush;
  assign w_rd = rd_en && !empty && !flush;

  // Show-ahead read: the sequencer needs the head entry at the pop edge
  // to chain entries without an idle cycle.
  assign rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + LVL_W'(1);
        2'b01:   r_count <= r_count - LVL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : signal_seq_fifo

// File: rtl/signal_sequence_driver_bfm.sv
// -----------------------------------------------------------------------------
// signal_sequence_driver_bfm
// Purpose : queued signal driver. Each pushed entry (value, mask, hold) is
//   applied to signals_out at a clock edge and held for hold+1 cycles;
//   queued entries drain back-to-back with no idle cycle between them.
// Ports:
//   clock, reset_n  : clock (posedge), async active-low reset
//   push_if         : push handshake (slave modport)
//   return_default  : 1 = drive default_signals once the queue drains / on flush
//   default_signals : idle value used when return_default = 1
//   flush           : synchronous clear of queue and active entry
//   signals_out     : driven signals (registered)
//   busy            : an entry is currently being applied
//   level           : entries queued, excluding the active one
//   applied_count   : entries popped (SIGNAL_SEQ_STATS_EN only, wraps)
//   overflow_count  : rejected pushes (SIGNAL_SEQ_STATS_EN only, saturates)
// Build option: define SIGNAL_SEQ_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module signal_sequence_driver_bfm
  import signal_seq_pkg::*;
#(
  parameter int                     SIGNAL_SIZE = 4,
  parameter int                     DEPTH       = 8,
  parameter int                     HOLD_W      = 8,
  parameter logic [SIGNAL_SIZE-1:0] RESET_VALUE = '0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  signal_sequence_driver_bfm_if.slave  push_if,
  input  logic                         return_default,
  input  logic [SIGNAL_SIZE-1:0]       default_signals,
  input  logic                         flush,
  output logic [SIGNAL_SIZE-1:0]       signals_out,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef SIGNAL_SEQ_STATS_EN
  ,
  output logic [STATS_CNT_W-1:0]       applied_count,
  output logic [OVF_CNT_W-1:0]         overflow_count
`endif
);
  localparam int ENTRY_W = entry_width(SIGNAL_SIZE, HOLD_W);

  seq_state_e             r_state;
  logic [HOLD_W-1:0]      r_cnt;
  logic [SIGNAL_SIZE-1:0] r_out;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic [ENTRY_W-1:0]     w_wr_data;
  logic [ENTRY_W-1:0]     w_head;
  logic [HOLD_W-1:0]      w_head_hold;
  logic [SIGNAL_SIZE-1:0] w_head_mask;
  logic [SIGNAL_SIZE-1:0] w_head_value;
  logic [SIGNAL_SIZE-1:0] w_applied;

  assign w_wr_data = {push_if.push_hold, push_if.push_mask, push_if.push_signals};

  assign w_head_hold  = w_head[ENTRY_W-1 -: HOLD_W];
  assign w_head_mask  = w_head[2*SIGNAL_SIZE-1 -: SIGNAL_SIZE];
  assign w_head_value = w_head[SIGNAL_SIZE-1:0];

  // Pop whenever the sequencer is free to take a new entry: idle, or the
  // active entry is in its last cycle.
  assign w_pop = !flush && !w_empty && ((r_state == SEQ_IDLE) || (r_cnt == '0));

  signal_seq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (push_if.push_valid),
    .wr_data (w_wr_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .flush   (flush),
    .full    (w_full),
    .empty   (w_empty),
    .level   (level)
  );

  assign push_if.push_ready = !w_full;

  // Masked merge of the head entry onto the current output.
  for (genvar gi = 0; gi < SIGNAL_SIZE; gi++) begin : g_merge
    assign w_applied[gi] = w_head_mask[gi] ? w_head_value[gi] : r_out[gi];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SEQ_IDLE;
      r_cnt   <= '0;
      r_out   <= RESET_VALUE;
    end else if (flush) begin
      r_state <= SEQ_IDLE;
      r_cnt   <= '0;
      if (return_default) r_out <= default_signals;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (!w_empty) begin
            r_out   <= w_applied;
            r_cnt   <= w_head_hold;
            r_state <= SEQ_APPLY;
          end
        end
        SEQ_APPLY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - HOLD_W'(1);
          end else if (!w_empty) begin
            r_out <= w_applied;
            r_cnt <= w_head_hold;
          end else begin
            r_state <= SEQ_IDLE;
            if (return_default) r_out <= default_signals;
          end
        end
        default: r_state <= SEQ_IDLE;
      endcase
    end
  end

  assign signals_out = r_out;
  assign busy        = (r_state == SEQ_APPLY);

`ifdef SIGNAL_SEQ_STATS_EN
  logic [STATS_CNT_W-1:0] r_applied_count;
  logic [OVF_CNT_W-1:0]   r_overflow_count;

  // Counters survive flush; only reset_n clears them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_applied_count  <= '0;
      r_overflow_count <= '0;
    end else begin
      if (w_pop) r_applied_count <= r_applied_count + STATS_CNT_W'(1);
      if (push_if.push_valid && w_full && (r_overflow_count != '1))
        r_overflow_count <= r_overflow_count + OVF_CNT_W'(1);
    end
  end

  assign applied_count  = r_applied_count;
  assign overflow_count = r_overflow_count;
`endif

endmodule : signal_sequence_driver_bfm
